// File: rtl/tt_um_borrow_select_sub_seq.sv
// Digit-serial subtractor: one DIGIT slice per cycle, LSB first, with borrow-select slice variants.
// Build option: define BSUB_SATURATE_EN to clamp out_diff to 0 in DONE when out_borrow is set.
module tt_um_borrow_select_sub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_r;
  logic             brw, borrow_r, ovf_r;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] a_d, b_d;
  logic [DIGIT:0]   s0, s1, sel;
  logic             last, accept, release_res;

  assign a_d         = a_sh[DIGIT-1:0];
  assign b_d         = b_sh[DIGIT-1:0];
  assign s0          = {1'b0, a_d} + {1'b0, ~b_d} + {{DIGIT{1'b0}}, 1'b1};
  assign s1          = {1'b0, a_d} + {1'b0, ~b_d};
  assign sel         = brw ? s1 : s0;
  assign last        = (idx == IW'(NDIG - 1));
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    out_borrow = borrow_r;
    out_ovf    = ovf_r;
`ifdef BSUB_SATURATE_EN
    out_diff   = (state == DONE && borrow_r) ? '0 : diff_r;
`else
    out_diff   = diff_r;
`endif
  end

  // Operands shift right so the active slice is always the low DIGIT bits;
  // at the last slice those bits hold the operand sign bits for overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_r   <= '0;
      brw      <= 1'b0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
      idx      <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_sh <= in_a;
        b_sh <= in_b;
        brw  <= 1'b0;
        idx  <= '0;
      end
    end else if (state == BUSY) begin
      diff_r[idx*DIGIT +: DIGIT] <= sel[DIGIT-1:0];
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      brw  <= ~sel[DIGIT];
      if (last) begin
        idx      <= '0;
        borrow_r <= ~sel[DIGIT];
        ovf_r    <= (a_d[DIGIT-1] != b_d[DIGIT-1]) && (sel[DIGIT-1] != a_d[DIGIT-1]);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tt_um_borrow_select_sub_seq.sv
// Directed bench for the digit-serial subtractor with a scoreboard of expected results.
module tb_tt_um_borrow_select_sub_seq;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_ovf;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];

  tt_um_borrow_select_sub_seq #(.WIDTH(8), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r.d = a - b;
    r.b = (a < b);
    r.o = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
`ifdef BSUB_SATURATE_EN
    if (r.b) r.d = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation; stall = cycles of out_ready low once out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit noise);
    res_t exp;
    int   n;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd2);
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_a = W'($urandom);
        in_b = W'($urandom);
      end
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      if (sb.size() > 0) chk("hold_diff", {24'd0, out_diff}, {24'd0, sb[0].d});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("diff", {24'd0, out_diff}, {24'd0, exp.d});
      chk("borrow", {31'd0, out_borrow}, {31'd0, exp.b});
      chk("ovf", {31'd0, out_ovf}, {31'd0, exp.o});
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
`ifndef BSUB_SATURATE_EN
    chk("diff_held", {24'd0, out_diff}, {24'd0, W'(a - b)});
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {24'd0, out_diff}, 32'd0);
    chk("rst_borrow", {31'd0, out_borrow}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);

    run_op(8'h5A, 8'h3C, 0, 1'b0);
    run_op(8'h00, 8'h01, 0, 1'b0);
    run_op(8'h80, 8'h01, 1, 1'b0);
    run_op(8'h10, 8'h01, 0, 1'b0);
    run_op(8'hF0, 8'h0F, 5, 1'b1);
    run_op(8'h7F, 8'hFF, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 2, 1'b0);

    // Abort: reset one cycle after an accept must discard the operation.
    @(negedge clk);
    in_a = 8'h33; in_b = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_diff", {24'd0, out_diff}, 32'd0);
    chk("abort_borrow", {31'd0, out_borrow}, 32'd0);
    chk("abort_ovf", {31'd0, out_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end

    run_op(8'h09, 8'h03, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), i, 1'b1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
